// File: rtl/prelu_stream.sv
`timescale 1ns/1ps
// Purpose : multi-lane streaming PReLU with runtime-loadable per-channel slopes.
// Latency : 2 cycles from input accept to m_* (S1 multiply, S2 round/saturate).
// Backpr. : adv = m_ready || !m_valid; s_ready = adv || !s1_valid; m_* hold while stalled.
//
// Ports   : clk_in/rst_in (async active-high reset); s_valid/s_ready/s_data/s_last
//           input stream (lane k = channel ch_base+k, lane 0 in LSBs);
//           m_valid/m_ready/m_data/m_last output stream; slope_we/slope_addr/
//           slope_wdata slope loader; align_err sticky misaligned-s_last flag.
// Option  : define PRELU_SAT_CNT_EN to add sat_clr input and sat_cnt[31:0] output
//           counting saturated lanes of beats handed downstream.
module prelu_stream #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 8,
  parameter int SLOPE_W = 16,
  parameter int LANES   = 4,
  parameter int NUM_CH  = 56
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES*DATA_W-1:0]   s_data,
  input  logic                      s_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [LANES*DATA_W-1:0]   m_data,
  output logic                      m_last,
  input  logic                      slope_we,
  input  logic [$clog2(NUM_CH)-1:0] slope_addr,
  input  logic [SLOPE_W-1:0]        slope_wdata,
  output logic                      align_err
`ifdef PRELU_SAT_CNT_EN
  ,
  input  logic                      sat_clr,
  output logic [31:0]               sat_cnt
`endif
);

  localparam int AW = $clog2(NUM_CH);
  localparam int PW = DATA_W + SLOPE_W;
  localparam logic [AW-1:0]         C_LAST_BASE = AW'(NUM_CH - LANES);
  localparam logic signed [SLOPE_W-1:0] C_SLOPE_DEF = SLOPE_W'(2**(FRAC_W-2));
  localparam logic signed [PW:0]    C_HALF = (PW+1)'(2**(FRAC_W-1));
  localparam logic signed [PW:0]    C_MAX  = {{(PW-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW:0]    C_MIN  = {{(PW-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [SLOPE_W-1:0] r_slope [NUM_CH];
  logic [AW-1:0]             r_ch_base;
  logic                      r_s1_valid;
  logic                      r_s1_last;
  logic signed [PW-1:0]      r_s1_prod [LANES];
  logic                      r_m_valid;
  logic                      r_m_last;
  logic [LANES*DATA_W-1:0]   r_m_data;
  logic                      r_align_err;

  logic                      w_adv;
  logic                      w_s_ready;
  logic                      w_accept;
  logic signed [PW-1:0]      w_prod [LANES];
  logic [LANES*DATA_W-1:0]   w_res;
`ifdef PRELU_SAT_CNT_EN
  logic [LANES-1:0]          w_sat;
  logic [LANES-1:0]          r_m_sat;
`endif

  assign w_adv     = m_ready || !r_m_valid;
  assign w_s_ready = w_adv || !r_s1_valid;
  assign w_accept  = s_valid && w_s_ready;

  assign s_ready   = w_s_ready;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;
  assign m_last    = r_m_last;
  assign align_err = r_align_err;

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      logic signed [DATA_W-1:0]  w_x;
      logic signed [SLOPE_W-1:0] w_slope;
      logic signed [PW:0]        w_sum;
      logic signed [PW:0]        w_y;

      assign w_x     = s_data[k*DATA_W +: DATA_W];
      assign w_slope = r_slope[r_ch_base + AW'(k)];
      // Non-negative samples are pre-scaled by 2^FRAC_W so the shared rounding
      // stage returns them unchanged.
      assign w_prod[k] = w_x[DATA_W-1] ? (PW'(w_x) * PW'(w_slope))
                                       : (PW'(w_x) <<< FRAC_W);
      // One guard bit keeps the rounding add from wrapping.
      assign w_sum = {r_s1_prod[k][PW-1], r_s1_prod[k]} + C_HALF;
      assign w_y   = w_sum >>> FRAC_W;
      assign w_res[k*DATA_W +: DATA_W] = (w_y > C_MAX) ? C_MAX[DATA_W-1:0] :
                                         (w_y < C_MIN) ? C_MIN[DATA_W-1:0] :
                                                         w_y[DATA_W-1:0];
`ifdef PRELU_SAT_CNT_EN
      assign w_sat[k] = (w_y > C_MAX) || (w_y < C_MIN);
`endif
    end
  endgenerate

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_CH; i++) r_slope[i] <= C_SLOPE_DEF;
      r_ch_base   <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      for (int i = 0; i < LANES; i++) r_s1_prod[i] <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_m_data    <= '0;
      r_align_err <= 1'b0;
`ifdef PRELU_SAT_CNT_EN
      r_m_sat     <= '0;
`endif
    end else begin
      if (slope_we && ({1'b0, slope_addr} < (AW+1)'(NUM_CH)))
        r_slope[slope_addr] <= slope_wdata;

      // S1: a beat is captured with the slope registered before this edge.
      if (w_s_ready) begin
        r_s1_valid <= s_valid;
        if (s_valid) begin
          r_s1_last <= s_last;
          for (int i = 0; i < LANES; i++) r_s1_prod[i] <= w_prod[i];
        end
      end

      if (w_accept) begin
        if (s_last || r_ch_base == C_LAST_BASE) r_ch_base <= '0;
        else                                    r_ch_base <= r_ch_base + AW'(LANES);
        if (s_last && r_ch_base != C_LAST_BASE) r_align_err <= 1'b1;
      end

      // S2: output register only moves when downstream can take it.
      if (w_adv) begin
        r_m_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_m_data <= w_res;
          r_m_last <= r_s1_last;
`ifdef PRELU_SAT_CNT_EN
          r_m_sat  <= w_sat;
`endif
        end
      end
    end
  end

`ifdef PRELU_SAT_CNT_EN
  localparam int CW = $clog2(LANES + 1);
  logic [CW-1:0] w_sat_num;
  logic [32:0]   w_cnt_sum;
  logic [31:0]   r_sat_cnt;

  always_comb begin
    w_sat_num = '0;
    for (int i = 0; i < LANES; i++) w_sat_num = w_sat_num + CW'(r_m_sat[i]);
  end
  assign w_cnt_sum = {1'b0, r_sat_cnt} + 33'(w_sat_num);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                     r_sat_cnt <= '0;
    else if (sat_clr)               r_sat_cnt <= '0;
    else if (r_m_valid && m_ready)  r_sat_cnt <= w_cnt_sum[32] ? '1 : w_cnt_sum[31:0];
  end
  assign sat_cnt = r_sat_cnt;
`endif

endmodule

// File: tb/tb_prelu_stream.sv
`timescale 1ns/1ps
module tb_prelu_stream;
  localparam int DW  = 16;
  localparam int LN  = 4;
  localparam int NCH = 8;
  localparam int BW  = LN * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last;
  logic [BW-1:0] s_data;
  logic          m_valid, m_ready, m_last;
  logic [BW-1:0] m_data;
  logic          slope_we;
  logic [2:0]    slope_addr;
  logic [15:0]   slope_wdata;
  logic          align_err;

  always #5 clk = ~clk;

  prelu_stream #(.DATA_W(16), .FRAC_W(8), .SLOPE_W(16), .LANES(LN), .NUM_CH(NCH)) dut (
    .clk_in(clk), .rst_in(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .slope_we(slope_we), .slope_addr(slope_addr), .slope_wdata(slope_wdata),
    .align_err(align_err)
  );

  typedef struct packed { logic [BW-1:0] d; logic l; } beat_t;
  beat_t sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    tb_slope[NCH];
  int    rdy_mode = 0;   // 0: ready high, 1: ready low, 2: pseudo-random

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  // Independent reference: full-precision product, round half up, clamp.
  function automatic int ref_lane(input int x, input int s);
    longint p, y;
    if (x >= 0) return x;
    p = longint'(x) * longint'(s);
    y = (p + 128) >>> 8;
    if (y > 32767)  return 32767;
    if (y < -32768) return -32768;
    return int'(y);
  endfunction

  // Downstream ready driver.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'b0;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pop on handshake plus stall-stability checks.
  logic          hold = 1'b0;
  logic [BW-1:0] hold_d;
  logic          hold_l;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("stall_valid", 64'(m_valid), 64'd1);
          check("stall_data", m_data, hold_d);
          check("stall_last", 64'(m_last), 64'(hold_l));
        end
        if (!s_ready) check("s_ready_low_only_when_full", 64'(m_valid && !m_ready), 64'd1);
        if (m_valid && m_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_beat", 64'(m_valid), 64'd0);
          end else begin
            beat_t e;
            e = sb_q.pop_front();
            check("out_data", m_data, e.d);
            check("out_last", 64'(m_last), 64'(e.l));
          end
        end
        hold   = m_valid && !m_ready;
        hold_d = m_data;
        hold_l = m_last;
      end
    end
  end

  task automatic send(input logic [BW-1:0] d, input logic l, input logic [BW-1:0] e, input bit push);
    bit acc;
    int guard;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    if (push) sb_q.push_back('{d: e, l: l});
    guard = 0;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic write_slope(input int addr, input logic [15:0] val);
    slope_we    = 1'b1;
    slope_addr  = 3'(addr);
    slope_wdata = val;
    @(posedge clk);
    #1;
    slope_we = 1'b0;
    tb_slope[addr] = int'($signed(val));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() != 0 && g < 300) begin
      @(posedge clk);
      g++;
    end
    check("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NCH; i++) tb_slope[i] = 64;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    slope_we = 1'b0; slope_addr = '0; slope_wdata = '0;
    #2;
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_align_err", 64'(align_err), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Default slope 0.25 on -1.0, with the 2-cycle latency check.
    send(pack4(-256, -256, -256, -256), 1'b0, pack4(-64, -64, -64, -64), 1'b1);
    check("lat_t1_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    check("lat_t2_valid", 64'(m_valid), 64'd1);
    send(pack4(-256, -256, -256, -256), 1'b1, pack4(-64, -64, -64, -64), 1'b1);

    // Loaded slope 1.5 on channel 5; positives and zero pass through.
    write_slope(5, 16'h0180);
    send(pack4(1000, 0, -1, 5), 1'b0, pack4(1000, 0, 0, 5), 1'b1);
    send(pack4(-256, -3, -32768, 100), 1'b1, pack4(-64, -4, -8192, 100), 1'b1);

    // Saturation at both rails and round-half-up.
    write_slope(6, 16'h7FFF);
    write_slope(7, 16'h8000);
    send(pack4(-2, -6, -1, 1), 1'b0, pack4(0, -1, 0, 1), 1'b1);
    send(pack4(-256, -3, -32768, -300), 1'b1, pack4(-64, -4, -32768, 32767), 1'b1);

    // Slope write in the capture cycle is not seen by that beat.
    slope_we = 1'b1; slope_addr = 3'd0; slope_wdata = 16'h0100;
    send(pack4(-256, -256, -256, -256), 1'b0, pack4(-64, -64, -64, -64), 1'b1);
    slope_we = 1'b0;
    tb_slope[0] = 256;
    send(pack4(0, 0, 0, 0), 1'b1, pack4(0, 0, 0, 0), 1'b1);

    // Misaligned s_last at ch_base 0, then a proper map from channel 0.
    check("align_before", 64'(align_err), 64'd0);
    send(pack4(-256, -256, -256, -256), 1'b1, pack4(-256, -64, -64, -64), 1'b1);
    check("align_set", 64'(align_err), 64'd1);
    send(pack4(-256, -256, -256, -256), 1'b0, pack4(-256, -64, -64, -64), 1'b1);
    send(pack4(-256, -256, -256, -256), 1'b1, pack4(-64, -384, -32767, 32767), 1'b1);
    check("align_sticky", 64'(align_err), 64'd1);
    drain();

    // Backpressure: 20 beats under pseudo-random m_ready.
    rdy_mode = 2;
    for (int i = 0; i < 20; i++) begin
      int x[LN];
      int y[LN];
      for (int k = 0; k < LN; k++) begin
        x[k] = (((i * LN + k) * 7919) % 65536) - 32768;
        y[k] = ref_lane(x[k], tb_slope[(i % 2) * LN + k]);
      end
      send(pack4(x[0], x[1], x[2], x[3]), 1'(i % 2), pack4(y[0], y[1], y[2], y[3]), 1'b1);
    end
    rdy_mode = 0;
    drain();

    // Async reset with two beats in flight.
    rdy_mode = 1;
    @(posedge clk);
    #2;
    send(pack4(-256, -256, -256, -256), 1'b0, '0, 1'b0);
    send(pack4(-3, -3, -3, -3), 1'b1, '0, 1'b0);
    check("inflight_valid", 64'(m_valid), 64'd1);
    check("inflight_s_ready", 64'(s_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_m_valid", 64'(m_valid), 64'd0);
    check("arst_m_data", m_data, 64'd0);
    check("arst_m_last", 64'(m_last), 64'd0);
    check("arst_s_ready", 64'(s_ready), 64'd1);
    check("arst_align_err", 64'(align_err), 64'd0);
    rdy_mode = 0;
    for (int i = 0; i < NCH; i++) tb_slope[i] = 64;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    send(pack4(-256, -256, -256, -256), 1'b0, pack4(-64, -64, -64, -64), 1'b1);
    send(pack4(-256, -3, -256, -256), 1'b1, pack4(-64, -1, -64, -64), 1'b1);
    drain();
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
